my_calc_axil_slave: RTL and testbench

- AXI4-Lite responder for the my_calc IP's S00_AXI port.
- Decodes single-beat reads and writes from the system master into a small register file. Drives a multi-cycle calculation engine: add, sub, sequential multiply, restoring divide. Returns results by register read.
- Sits directly behind the block-design AXI interconnect; it is the slave end that the master VIP drives in the IP bench.

---
 rtl/my_calc_axil_slave_if.sv | 51 +++++
 rtl/my_calc_axil_slave.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_my_calc_axil_slave.sv | 337 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/my_calc_axil_slave_if.sv
// AXI4-Lite bus bundle between the system master and the my_calc register slave.
interface my_calc_axil_slave_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
    logic [2:0]              S_AXI_AWPROT;
    logic                    S_AXI_AWVALID;
    logic                    S_AXI_AWREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
    logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
    logic                    S_AXI_WVALID;
    logic                    S_AXI_WREADY;
    logic [1:0]              S_AXI_BRESP;
    logic                    S_AXI_BVALID;
    logic                    S_AXI_BREADY;
    logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
    logic [2:0]              S_AXI_ARPROT;
    logic                    S_AXI_ARVALID;
    logic                    S_AXI_ARREADY;
    logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
    logic [1:0]              S_AXI_RRESP;
    logic                    S_AXI_RVALID;
    logic                    S_AXI_RREADY;

    modport slave (
        input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        output S_AXI_AWREADY,
        input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        output S_AXI_WREADY,
        output S_AXI_BRESP, S_AXI_BVALID,
        input  S_AXI_BREADY,
        input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        output S_AXI_ARREADY,
        output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        input  S_AXI_RREADY
    );

    modport master (
        output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
        input  S_AXI_AWREADY,
        output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
        input  S_AXI_WREADY,
        input  S_AXI_BRESP, S_AXI_BVALID,
        output S_AXI_BREADY,
        output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
        input  S_AXI_ARREADY,
        input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
        output S_AXI_RREADY
    );
endinterface

// File: rtl/my_calc_axil_slave.sv
// AXI4-Lite slave for my_calc: A/B/CTRL/RESULT register file driving an
// add/sub engine plus iterative shift-add multiplier and restoring divider.
module my_calc_axil_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CALC_CYCLES        = 32
) (
    input  logic                ACLK,
    input  logic                ARESETN,
    my_calc_axil_slave_if.slave s_axi,
    output logic                irq_done
);
    localparam int DW = C_S_AXI_DATA_WIDTH;
    localparam int SW = DW / 8;
    localparam int CW = $clog2(CALC_CYCLES);
    localparam logic [CW-1:0] LAST_ITER = CW'(CALC_CYCLES - 1);

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    localparam logic [1:0] ADDR_A    = 2'd0;
    localparam logic [1:0] ADDR_B    = 2'd1;
    localparam logic [1:0] ADDR_CTRL = 2'd2;
    localparam logic [1:0] ADDR_RES  = 2'd3;

    typedef enum logic [1:0] {
        ENG_IDLE,
        ENG_SINGLE,
        ENG_RUN
    } engState_e;

    logic          awReady_q, awReady_d;
    logic          wReady_q, wReady_d;
    logic          awHeld_q, awHeld_d;
    logic          wHeld_q, wHeld_d;
    logic [1:0]    awAddr_q, awAddr_d;
    logic [DW-1:0] wData_q, wData_d;
    logic [SW-1:0] wStrb_q, wStrb_d;
    logic          bValid_q, bValid_d;
    logic          arReady_q, arReady_d;
    logic          rValid_q, rValid_d;
    logic [DW-1:0] rData_q, rData_d;
    logic [1:0]    rAddr_q, rAddr_d;

    logic [DW-1:0] regA_q, regA_d;
    logic [DW-1:0] regB_q, regB_d;
    logic [1:0]    op_q, op_d;
    logic          ie_q, ie_d;

    engState_e     state_q;
    logic [1:0]    wkOp_q;
    logic [DW-1:0] wkA_q;
    logic [DW-1:0] wkB_q;
    logic [DW-1:0] acc_q;
    logic [CW-1:0] cnt_q;
    logic [DW-1:0] result_q;
    logic          busy_q;
    logic          done_q;
    logic          divz_q;

    logic          awHs, wHs, bHs, arHs, rHs;
    logic          doWrite;
    logic          startReq;
    logic          resultRdClr;
    logic [1:0]    startOp;
    logic [DW-1:0] ctrlRead;
    logic [DW-1:0] readMux;
    logic [DW-1:0] mulAccNext;
    logic [DW:0]   remShift;
    logic          divFits;
    logic [DW-1:0] divRemNext;
    logic [DW-1:0] quoNext;
    logic          unusedBits;

    function automatic logic [DW-1:0] mergeBytes(input logic [DW-1:0] oldVal,
                                                 input logic [DW-1:0] newVal,
                                                 input logic [SW-1:0] strb);
        logic [DW-1:0] merged;
        merged = oldVal;
        for (int i = 0; i < SW; i++) begin
            if (strb[i]) begin
                merged[i*8 +: 8] = newVal[i*8 +: 8];
            end
        end
        return merged;
    endfunction

    assign awHs    = s_axi.S_AXI_AWVALID & awReady_q;
    assign wHs     = s_axi.S_AXI_WVALID & wReady_q;
    assign bHs     = bValid_q & s_axi.S_AXI_BREADY;
    assign arHs    = s_axi.S_AXI_ARVALID & arReady_q;
    assign rHs     = rValid_q & s_axi.S_AXI_RREADY;
    assign doWrite = awHeld_q & wHeld_q & ~bValid_q;

    assign startOp     = wStrb_q[0] ? wData_q[1:0] : op_q;
    assign startReq    = doWrite & (awAddr_q == ADDR_CTRL) & wStrb_q[SW-1] & wData_q[DW-1];
    assign resultRdClr = rHs & (rAddr_q == ADDR_RES);

    assign ctrlRead = {1'b0, busy_q, done_q, divz_q, {(DW-7){1'b0}}, ie_q, op_q};

    // Reads sample the pre-write register values, so a same-cycle write is not visible yet
    always_comb begin
        readMux = '0;
        case (s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2])
            ADDR_A:    readMux = regA_q;
            ADDR_B:    readMux = regB_q;
            ADDR_CTRL: readMux = ctrlRead;
            default:   readMux = result_q;
        endcase
    end

    // Holds clear when the write commits; BVALID then masks the readies until the B handshake
    always_comb begin
        awHeld_d = awHeld_q | awHs;
        wHeld_d  = wHeld_q | wHs;
        bValid_d = bValid_q;
        if (doWrite) begin
            awHeld_d = 1'b0;
            wHeld_d  = 1'b0;
            bValid_d = 1'b1;
        end else if (bHs) begin
            bValid_d = 1'b0;
        end
        awReady_d = ~awHeld_d & ~bValid_d;
        wReady_d  = ~wHeld_d & ~bValid_d;
        awAddr_d  = awHs ? s_axi.S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2] : awAddr_q;
        wData_d   = wHs ? s_axi.S_AXI_WDATA : wData_q;
        wStrb_d   = wHs ? s_axi.S_AXI_WSTRB : wStrb_q;

        rValid_d  = rValid_q;
        rData_d   = rData_q;
        rAddr_d   = rAddr_q;
        if (arHs) begin
            rValid_d = 1'b1;
            rData_d  = readMux;
            rAddr_d  = s_axi.S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
        end else if (rHs) begin
            rValid_d = 1'b0;
        end
        arReady_d = ~rValid_d;

        regA_d = regA_q;
        regB_d = regB_q;
        op_d   = op_q;
        ie_d   = ie_q;
        if (doWrite) begin
            case (awAddr_q)
                ADDR_A: regA_d = mergeBytes(regA_q, wData_q, wStrb_q);
                ADDR_B: regB_d = mergeBytes(regB_q, wData_q, wStrb_q);
                ADDR_CTRL: begin
                    if (wStrb_q[0]) begin
                        op_d = wData_q[1:0];
                        ie_d = wData_q[2];
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            awReady_q <= 1'b0;
            wReady_q  <= 1'b0;
            awHeld_q  <= 1'b0;
            wHeld_q   <= 1'b0;
            awAddr_q  <= '0;
            wData_q   <= '0;
            wStrb_q   <= '0;
            bValid_q  <= 1'b0;
            arReady_q <= 1'b0;
            rValid_q  <= 1'b0;
            rData_q   <= '0;
            rAddr_q   <= '0;
            regA_q    <= '0;
            regB_q    <= '0;
            op_q      <= '0;
            ie_q      <= 1'b0;
        end else begin
            awReady_q <= awReady_d;
            wReady_q  <= wReady_d;
            awHeld_q  <= awHeld_d;
            wHeld_q   <= wHeld_d;
            awAddr_q  <= awAddr_d;
            wData_q   <= wData_d;
            wStrb_q   <= wStrb_d;
            bValid_q  <= bValid_d;
            arReady_q <= arReady_d;
            rValid_q  <= rValid_d;
            rData_q   <= rData_d;
            rAddr_q   <= rAddr_d;
            regA_q    <= regA_d;
            regB_q    <= regB_d;
            op_q      <= op_d;
            ie_q      <= ie_d;
        end
    end

    // One iteration of each algorithm; wkA/wkB double as multiplicand/multiplier or quotient/divisor
    assign mulAccNext = acc_q + (wkB_q[0] ? wkA_q : '0);
    assign remShift   = {acc_q, wkA_q[DW-1]};
    assign divFits    = remShift >= {1'b0, wkB_q};
    assign divRemNext = divFits ? (remShift[DW-1:0] - wkB_q) : remShift[DW-1:0];
    assign quoNext    = {wkA_q[DW-2:0], divFits};

    // A DONE set in the same cycle as a RESULT read wins because it is assigned last
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q  <= ENG_IDLE;
            wkOp_q   <= '0;
            wkA_q    <= '0;
            wkB_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            divz_q   <= 1'b0;
        end else begin
            if (resultRdClr) begin
                done_q <= 1'b0;
            end
            case (state_q)
                ENG_IDLE: begin
                    if (startReq) begin
                        wkOp_q <= startOp;
                        wkA_q  <= regA_q;
                        wkB_q  <= regB_q;
                        acc_q  <= '0;
                        cnt_q  <= '0;
                        busy_q <= 1'b1;
                        done_q <= 1'b0;
                        divz_q <= 1'b0;
                        if (startOp == OP_MUL || (startOp == OP_DIV && regB_q != '0)) begin
                            state_q <= ENG_RUN;
                        end else begin
                            state_q <= ENG_SINGLE;
                        end
                    end
                end
                ENG_SINGLE: begin
                    case (wkOp_q)
                        OP_ADD:  result_q <= wkA_q + wkB_q;
                        OP_SUB:  result_q <= wkA_q - wkB_q;
                        default: result_q <= '1;
                    endcase
                    divz_q  <= (wkOp_q == OP_DIV);
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= ENG_IDLE;
                end
                ENG_RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (wkOp_q == OP_MUL) begin
                        acc_q <= mulAccNext;
                        wkA_q <= wkA_q << 1;
                        wkB_q <= wkB_q >> 1;
                    end else begin
                        acc_q <= divRemNext;
                        wkA_q <= quoNext;
                    end
                    if (cnt_q == LAST_ITER) begin
                        result_q <= (wkOp_q == OP_MUL) ? mulAccNext : quoNext;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ENG_IDLE;
                    end
                end
                default: state_q <= ENG_IDLE;
            endcase
        end
    end

    assign s_axi.S_AXI_AWREADY = awReady_q;
    assign s_axi.S_AXI_WREADY  = wReady_q;
    assign s_axi.S_AXI_BVALID  = bValid_q;
    assign s_axi.S_AXI_BRESP   = 2'b00;
    assign s_axi.S_AXI_ARREADY = arReady_q;
    assign s_axi.S_AXI_RVALID  = rValid_q;
    assign s_axi.S_AXI_RDATA   = rData_q;
    assign s_axi.S_AXI_RRESP   = 2'b00;
    assign irq_done            = done_q & ie_q;

    assign unusedBits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT,
                          s_axi.S_AXI_AWADDR[1:0], s_axi.S_AXI_ARADDR[1:0]};

endmodule

// File: tb/tb_my_calc_axil_slave.sv
// Self-checking bench for my_calc_axil_slave: directed protocol/engine steps
// followed by randomized operations compared against an arithmetic model.
module tb_my_calc_axil_slave;
    localparam int CALC_CYCLES = 32;
    localparam logic [3:0] A_ADDR    = 4'h0;
    localparam logic [3:0] B_ADDR    = 4'h4;
    localparam logic [3:0] CTRL_ADDR = 4'h8;
    localparam logic [3:0] RES_ADDR  = 4'hC;

    logic ACLK = 1'b0;
    logic ARESETN = 1'b0;
    logic irq_done;
    int   errors = 0;
    int   checks = 0;

    my_calc_axil_slave_if #(.DATA_WIDTH(32), .ADDR_WIDTH(4)) axi ();

    my_calc_axil_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(4),
        .CALC_CYCLES(CALC_CYCLES)
    ) dut (
        .ACLK(ACLK),
        .ARESETN(ARESETN),
        .s_axi(axi),
        .irq_done(irq_done)
    );

    always #5 ACLK = ~ACLK;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Spec-level results: plain arithmetic, divide-by-zero saturates to all ones
    function automatic logic [31:0] modelResult(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] prod;
        case (op)
            2'd0: return a + b;
            2'd1: return a - b;
            2'd2: begin
                prod = {32'd0, a} * {32'd0, b};
                return prod[31:0];
            end
            default: return (b == 0) ? 32'hFFFF_FFFF : a / b;
        endcase
    endfunction

    function automatic logic [31:0] modelStrobe(input logic [31:0] oldVal, input logic [31:0] newVal, input logic [3:0] strb);
        logic [31:0] mask;
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return (oldVal & ~mask) | (newVal & mask);
    endfunction

    task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awDly, input int wDly, input int bDly);
        int cyc;
        bit awDone, wDone, awGo, wGo, gotB;
        @(negedge ACLK);
        axi.S_AXI_AWADDR = addr;
        axi.S_AXI_WDATA  = data;
        axi.S_AXI_WSTRB  = strb;
        awDone = 0;
        wDone  = 0;
        cyc    = 0;
        while (!(awDone && wDone) && cyc < 64) begin
            axi.S_AXI_AWVALID = !awDone && (cyc >= awDly);
            axi.S_AXI_WVALID  = !wDone && (cyc >= wDly);
            awGo = axi.S_AXI_AWVALID && axi.S_AXI_AWREADY;
            wGo  = axi.S_AXI_WVALID && axi.S_AXI_WREADY;
            @(negedge ACLK);
            if (awGo) awDone = 1;
            if (wGo) wDone = 1;
            cyc++;
        end
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WVALID  = 1'b0;
        checkOutput("write AW+W accepted", {30'd0, awDone, wDone}, 32'd3);
        cyc  = 0;
        gotB = 0;
        while (!gotB && cyc < 64) begin
            axi.S_AXI_BREADY = (cyc >= bDly);
            if (axi.S_AXI_BVALID) begin
                checkOutput("no AW/W ready while BVALID", {30'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY}, 32'd0);
                if (axi.S_AXI_BREADY) begin
                    checkOutput("BRESP", {30'd0, axi.S_AXI_BRESP}, 32'd0);
                    gotB = 1;
                end
            end
            @(negedge ACLK);
            cyc++;
        end
        axi.S_AXI_BREADY = 1'b0;
        checkOutput("B response seen", {31'd0, gotB}, 32'd1);
        checkOutput("single BVALID per write", {31'd0, axi.S_AXI_BVALID}, 32'd0);
    endtask

    task automatic writeReg(input logic [3:0] addr, input logic [31:0] data);
        axiWrite(addr, data, 4'hF, 0, 0, 0);
    endtask

    task automatic axiRead(input logic [3:0] addr, output logic [31:0] data);
        int cyc;
        @(negedge ACLK);
        axi.S_AXI_ARADDR  = addr;
        axi.S_AXI_ARVALID = 1'b1;
        cyc = 0;
        while (!axi.S_AXI_ARREADY && cyc < 64) begin
            @(negedge ACLK);
            cyc++;
        end
        checkOutput("AR accepted in budget", {31'd0, axi.S_AXI_ARREADY}, 32'd1);
        @(negedge ACLK);
        axi.S_AXI_ARVALID = 1'b0;
        checkOutput("RVALID after AR", {31'd0, axi.S_AXI_RVALID}, 32'd1);
        checkOutput("RRESP", {30'd0, axi.S_AXI_RRESP}, 32'd0);
        data = axi.S_AXI_RDATA;
        axi.S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        axi.S_AXI_RREADY = 1'b0;
    endtask

    task automatic pollDone(output logic [31:0] ctrl);
        int n;
        n = 0;
        axiRead(CTRL_ADDR, ctrl);
        while (!ctrl[29] && n < 40) begin
            axiRead(CTRL_ADDR, ctrl);
            n++;
        end
        checkOutput("DONE within poll budget", {31'd0, ctrl[29]}, 32'd1);
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput(tag, {24'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_BVALID,
                          axi.S_AXI_ARREADY, axi.S_AXI_RVALID, irq_done,
                          axi.S_AXI_BRESP[0] | axi.S_AXI_BRESP[1],
                          axi.S_AXI_RRESP[0] | axi.S_AXI_RRESP[1]}, 32'd0);
        checkOutput({tag, " rdata"}, axi.S_AXI_RDATA, 32'd0);
    endtask

    // One randomized operation: masked A write, B write, START, then result/flag checks
    task automatic applyStimulus(input int iter);
        logic [31:0] a, b, d, rd;
        logic [3:0]  strb;
        logic [1:0]  op;
        logic        ie, divzExp;
        a    = $urandom;
        b    = $urandom;
        d    = $urandom;
        strb = 4'($urandom_range(0, 15));
        op   = 2'($urandom_range(0, 3));
        ie   = 1'($urandom_range(0, 1));
        if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 2));
        axiWrite(A_ADDR, a, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        axiWrite(A_ADDR, d, strb, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
        a = modelStrobe(a, d, strb);
        axiRead(A_ADDR, rd);
        checkOutput("rand A strobe readback", rd, a);
        writeReg(B_ADDR, b);
        writeReg(CTRL_ADDR, {1'b1, 28'd0, ie, op});
        divzExp = (op == 2'd3) && (b == 0);
        pollDone(rd);
        checkOutput("rand flags at done", {28'd0, rd[31:28]}, {29'd0, 1'b0, 1'b1, divzExp});
        checkOutput("rand irq at done", {31'd0, irq_done}, {31'd0, ie});
        axiRead(RES_ADDR, rd);
        checkOutput($sformatf("rand result it%0d op%0d", iter, op), rd, modelResult(op, a, b));
        checkOutput("rand irq after RESULT read", {31'd0, irq_done}, 32'd0);
        axiRead(CTRL_ADDR, rd);
        checkOutput("rand CTRL after RESULT read", rd, {3'b000, divzExp, 25'd0, ie, op});
    endtask

    initial begin
        logic [31:0] rd, first;
        int lat;
        axi.S_AXI_AWADDR  = '0;
        axi.S_AXI_AWPROT  = '0;
        axi.S_AXI_AWVALID = 1'b0;
        axi.S_AXI_WDATA   = '0;
        axi.S_AXI_WSTRB   = '0;
        axi.S_AXI_WVALID  = 1'b0;
        axi.S_AXI_BREADY  = 1'b0;
        axi.S_AXI_ARADDR  = '0;
        axi.S_AXI_ARPROT  = '0;
        axi.S_AXI_ARVALID = 1'b0;
        axi.S_AXI_RREADY  = 1'b0;

        repeat (3) @(negedge ACLK);
        checkResetOutputs("reset outputs");
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        checkOutput("readies after reset", {29'd0, axi.S_AXI_AWREADY, axi.S_AXI_WREADY, axi.S_AXI_ARREADY}, 32'd7);

        $display("[TB] add: 5 + 7");
        writeReg(A_ADDR, 32'd5);
        writeReg(B_ADDR, 32'd7);
        writeReg(CTRL_ADDR, 32'h8000_0000);
        axiRead(CTRL_ADDR, rd);
        checkOutput("add CTRL DONE immediately", rd, 32'h2000_0000);
        axiRead(RES_ADDR, rd);
        checkOutput("add RESULT", rd, 32'h0000_000C);
        axiRead(CTRL_ADDR, rd);
        checkOutput("add DONE cleared by RESULT read", rd, 32'h0000_0000);

        $display("[TB] mul with IE: 0x1234 * 0x10");
        writeReg(A_ADDR, 32'h0000_1234);
        writeReg(B_ADDR, 32'h0000_0010);
        writeReg(CTRL_ADDR, 32'h8000_0006);
        // BUSY spans CALC_CYCLES cycles and the B handshake closes the first of them
        lat = 0;
        while (!irq_done && lat < 200) begin
            @(negedge ACLK);
            lat++;
        end
        checkOutput("mul irq latency after B", lat, CALC_CYCLES - 1);
        axiRead(RES_ADDR, rd);
        checkOutput("mul RESULT", rd, 32'h0001_2340);
        checkOutput("irq dropped by RESULT read", {31'd0, irq_done}, 32'd0);

        $display("[TB] mul with writes and START during RUN");
        writeReg(A_ADDR, 32'd7);
        writeReg(B_ADDR, 32'd9);
        writeReg(CTRL_ADDR, 32'h8000_0002);
        axiRead(CTRL_ADDR, rd);
        checkOutput("mul BUSY set, DONE clear", {28'd0, rd[31:28]}, 32'h4);
        writeReg(A_ADDR, 32'hDEAD_BEEF);
        writeReg(CTRL_ADDR, 32'h8000_0000);
        pollDone(rd);
        checkOutput("mul flags after ignored START", {28'd0, rd[31:28]}, 32'h2);
        axiRead(RES_ADDR, rd);
        checkOutput("mul RESULT undisturbed", rd, 32'd63);
        axiRead(A_ADDR, rd);
        checkOutput("A written during RUN", rd, 32'hDEAD_BEEF);

        $display("[TB] div 100 / 7 and divide by zero");
        writeReg(A_ADDR, 32'd100);
        writeReg(B_ADDR, 32'd7);
        writeReg(CTRL_ADDR, 32'h8000_0003);
        pollDone(rd);
        checkOutput("div flags", {28'd0, rd[31:28]}, 32'h2);
        axiRead(RES_ADDR, rd);
        checkOutput("div RESULT", rd, 32'd14);
        writeReg(B_ADDR, 32'd0);
        writeReg(CTRL_ADDR, 32'h8000_0003);
        axiRead(CTRL_ADDR, rd);
        checkOutput("div0 CTRL DONE+DIVZ", rd, 32'h3000_0003);
        axiRead(RES_ADDR, rd);
        checkOutput("div0 RESULT", rd, 32'hFFFF_FFFF);

        $display("[TB] skewed AW/W with stalled BREADY");
        axiWrite(A_ADDR, 32'hA5A5_0001, 4'hF, 0, 3, 5);
        axiWrite(B_ADDR, 32'h0BAD_F00D, 4'hF, 3, 0, 5);
        axiRead(A_ADDR, rd);
        checkOutput("skew A readback", rd, 32'hA5A5_0001);
        axiRead(B_ADDR, rd);
        checkOutput("skew B readback", rd, 32'h0BAD_F00D);

        $display("[TB] byte strobes and back-to-back reads");
        writeReg(A_ADDR, 32'hFFFF_FFFF);
        axiWrite(A_ADDR, 32'h0000_AB00, 4'b0010, 0, 0, 0);
        axiRead(A_ADDR, rd);
        checkOutput("strobed A", rd, 32'hFFFF_ABFF);

        @(negedge ACLK);
        axi.S_AXI_ARADDR  = A_ADDR;
        axi.S_AXI_ARVALID = 1'b1;
        lat = 0;
        while (!axi.S_AXI_ARREADY && lat < 64) begin
            @(negedge ACLK);
            lat++;
        end
        @(negedge ACLK);
        axi.S_AXI_ARADDR = B_ADDR;
        checkOutput("b2b first RVALID", {31'd0, axi.S_AXI_RVALID}, 32'd1);
        first = axi.S_AXI_RDATA;
        for (int i = 0; i < 4; i++) begin
            @(negedge ACLK);
            checkOutput("b2b RDATA stable", axi.S_AXI_RDATA, first);
            checkOutput("b2b ARREADY low while stalled", {31'd0, axi.S_AXI_ARREADY}, 32'd0);
        end
        checkOutput("b2b first data", first, 32'hFFFF_ABFF);
        axi.S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        checkOutput("b2b ARREADY after R", {30'd0, axi.S_AXI_ARREADY, axi.S_AXI_RVALID}, 32'd2);
        @(negedge ACLK);
        axi.S_AXI_ARVALID = 1'b0;
        checkOutput("b2b second RVALID", {31'd0, axi.S_AXI_RVALID}, 32'd1);
        checkOutput("b2b second data", axi.S_AXI_RDATA, 32'h0BAD_F00D);
        @(negedge ACLK);
        axi.S_AXI_RREADY = 1'b0;

        $display("[TB] reset during mul RUN");
        writeReg(A_ADDR, 32'h0000_0003);
        writeReg(B_ADDR, 32'h0000_0005);
        writeReg(CTRL_ADDR, 32'h8000_0006);
        repeat (9) @(negedge ACLK);
        ARESETN = 1'b0;
        #1;
        checkResetOutputs("async reset outputs");
        for (int i = 0; i < 3; i++) begin
            @(negedge ACLK);
            checkResetOutputs("held reset outputs");
        end
        ARESETN = 1'b1;
        repeat (2) @(negedge ACLK);
        axiRead(CTRL_ADDR, rd);
        checkOutput("CTRL after reset", rd, 32'd0);
        axiRead(RES_ADDR, rd);
        checkOutput("RESULT after reset", rd, 32'd0);
        axiRead(A_ADDR, rd);
        checkOutput("A after reset", rd, 32'd0);
        writeReg(A_ADDR, 32'd3);
        writeReg(B_ADDR, 32'd4);
        writeReg(CTRL_ADDR, 32'h8000_0000);
        pollDone(rd);
        axiRead(RES_ADDR, rd);
        checkOutput("add after reset", rd, 32'd7);

        $display("[TB] randomized operations");
        for (int it = 0; it < 12; it++) begin
            applyStimulus(it);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
